qr_cordic_arbiter: RTL and testbench

Shares one `QR_CORDIC` engine between two stream requesters (channel 0, channel 1) inside the YOLO top. Grants whole matrices round-robin and feeds `NUM_COL` column words into the core. Captures the core result and writes it as one tagged beat to the shared output stream. Adds framing-error and core-timeout detection so a hung core or malformed matrix cannot lock the datapath.

---
 rtl/qr_pkg.sv | 8 +
 rtl/rr_arb2.sv | 20 ++
 rtl/qr_cordic_arbiter.sv | 110 +++++++++++
 tb/tb_qr_cordic_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// qr_pkg: shared constants and state encoding for the QR CORDIC arbiter
// DATA_LENGTH/NUM_COL describe the core word; CH_W is the channel id width.
package qr_pkg;
    localparam int DATA_LENGTH = 13;
    localparam int NUM_COL = 8;
    localparam int CH_W = 1;
    typedef enum logic [1:0] {IDLE, READ, WAIT, WB} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin arbiter, pointer moves on advance
// req: channel requests, advance: matrix finished, last_gnt: channel that finished,
// gnt: winning channel, any: at least one request present.
module rr_arb2 import qr_pkg::*; (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic            advance,
    input  logic [CH_W-1:0] last_gnt,
    output logic [CH_W-1:0] gnt,
    output logic            any
);
    logic ptr;
    assign any = |req;
    // Contention goes to the pointer channel, otherwise whoever is asking.
    assign gnt = &req ? ptr : req[1];
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= 1'b0;
        else if (advance) ptr <= ~last_gnt;
endmodule

// File: rtl/qr_cordic_arbiter.sv
// qr_cordic_arbiter: shares one QR_CORDIC core between two matrix streams
// s0_*/s1_*: input channels (data, last, empty_n, read); osif_*: tagged output stream;
// qr_*: core input/result handshake; busy/err_frame/err_timeout: status pulses.
module qr_cordic_arbiter import qr_pkg::*; #(
    parameter int TBITS       = 64,
    parameter int TBYTE       = 8,
    parameter int DATA_LENGTH = qr_pkg::DATA_LENGTH,
    parameter int NUM_COL     = qr_pkg::NUM_COL,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TBITS-1:0]         s0_data_dout,
    input  logic                     s0_last_dout,
    input  logic                     s0_empty_n,
    output logic                     s0_read,
    input  logic [TBITS-1:0]         s1_data_dout,
    input  logic                     s1_last_dout,
    input  logic                     s1_empty_n,
    output logic                     s1_read,
    output logic [TBITS-1:0]         osif_data_din,
    output logic [TBYTE-1:0]         osif_strb_din,
    output logic                     osif_last_din,
    output logic                     osif_user_din,
    input  logic                     osif_full_n,
    output logic                     osif_write,
    output logic                     qr_valid,
    output logic [4*DATA_LENGTH-1:0] qr_in,
    input  logic                     qr_out_valid,
    input  logic [4*DATA_LENGTH-1:0] qr_out,
    output logic                     busy,
    output logic                     err_frame,
    output logic                     err_timeout
);
    localparam int W  = 4*DATA_LENGTH;
    localparam int CW = $clog2(NUM_COL);
    localparam int TW = $clog2(TIMEOUT+1);
    state_t          state, state_n;
    logic            gnt_id, arb_gnt, arb_any, advance;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   tcnt;
    logic [W-1:0]    result, rd_data;
    logic            ferr_seen, rd_en, rd_last, beat_last, timeout_hit;
    logic            unused_hi;
    assign unused_hi = ^{s0_data_dout[TBITS-1:W], s1_data_dout[TBITS-1:W]};
    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      ({s1_empty_n, s0_empty_n}),
        .advance  (advance),
        .last_gnt (gnt_id),
        .gnt      (arb_gnt),
        .any      (arb_any)
    );
    assign rd_data   = gnt_id ? s1_data_dout[W-1:0] : s0_data_dout[W-1:0];
    assign rd_last   = gnt_id ? s1_last_dout : s0_last_dout;
    assign rd_en     = state == READ && (gnt_id ? s1_empty_n : s0_empty_n);
    assign s0_read   = rd_en & ~gnt_id;
    assign s1_read   = rd_en & gnt_id;
    assign qr_valid  = rd_en;
    assign qr_in     = rd_en ? rd_data : '0;
    assign beat_last = cnt == CW'(NUM_COL-1);
    // Only the first offending beat of a matrix reports; the matrix is still consumed whole.
    assign err_frame = rd_en & (rd_last != beat_last) & ~ferr_seen;
    // Last WAIT cycle without a result; the registered pulse lands as WAIT is left.
    assign timeout_hit = state == WAIT && !qr_out_valid && tcnt == TW'(TIMEOUT-1);
    assign osif_write    = state == WB && osif_full_n;
    assign advance       = osif_write | timeout_hit;
    assign osif_data_din = {{(TBITS-W){1'b0}}, result};
    assign osif_strb_din = '1;
    assign osif_last_din = osif_write;
    assign osif_user_din = state == WB && gnt_id;
    assign busy          = state != IDLE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = arb_any ? READ : IDLE;
            READ:    state_n = rd_en && beat_last ? WAIT : READ;
            WAIT:    state_n = qr_out_valid ? WB : timeout_hit ? IDLE : WAIT;
            WB:      state_n = osif_full_n ? IDLE : WB;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt_id      <= 1'b0;
            cnt         <= '0;
            tcnt        <= '0;
            result      <= '0;
            ferr_seen   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            err_timeout <= timeout_hit;
            if (state == IDLE) begin
                cnt       <= '0;
                tcnt      <= '0;
                ferr_seen <= 1'b0;
                if (arb_any) gnt_id <= arb_gnt;
            end
            if (rd_en) cnt <= cnt + 1'b1;
            if (err_frame) ferr_seen <= 1'b1;
            if (state == WAIT) begin
                tcnt <= tcnt + 1'b1;
                if (qr_out_valid) result <= qr_out;
            end
        end
    end
endmodule

// File: tb/tb_qr_cordic_arbiter.sv
// tb_qr_cordic_arbiter: directed scoreboard bench for qr_cordic_arbiter
module tb_qr_cordic_arbiter;
    localparam int TB = 64, W = 52, NC = 8, TO = 255;
    typedef struct {logic user; logic [63:0] data;} exp_t;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic [TB-1:0] s0_data_dout, s1_data_dout, osif_data_din;
    logic s0_last_dout, s1_last_dout, s0_empty_n, s1_empty_n, s0_read, s1_read;
    logic [7:0] osif_strb_din;
    logic osif_last_din, osif_user_din, osif_full_n, osif_write, qr_valid, qr_out_valid;
    logic [W-1:0] qr_in, qr_out;
    logic busy, err_frame, err_timeout;
    qr_cordic_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_data_dout(s0_data_dout), .s0_last_dout(s0_last_dout), .s0_empty_n(s0_empty_n), .s0_read(s0_read),
        .s1_data_dout(s1_data_dout), .s1_last_dout(s1_last_dout), .s1_empty_n(s1_empty_n), .s1_read(s1_read),
        .osif_data_din(osif_data_din), .osif_strb_din(osif_strb_din), .osif_last_din(osif_last_din),
        .osif_user_din(osif_user_din), .osif_full_n(osif_full_n), .osif_write(osif_write),
        .qr_valid(qr_valid), .qr_in(qr_in), .qr_out_valid(qr_out_valid), .qr_out(qr_out),
        .busy(busy), .err_frame(err_frame), .err_timeout(err_timeout)
    );
    // Channel sources: word memories with bench-owned fill limit, DUT-driven read pointer.
    logic [64:0] mem0 [256];
    logic [64:0] mem1 [256];
    int lim0 = 0, lim1 = 0, rd0 = 0, rd1 = 0;
    logic en0 = 0, en1 = 0;
    assign s0_empty_n   = en0 && rd0 < lim0;
    assign s1_empty_n   = en1 && rd1 < lim1;
    assign s0_data_dout = mem0[rd0[7:0]][63:0];
    assign s0_last_dout = mem0[rd0[7:0]][64];
    assign s1_data_dout = mem1[rd1[7:0]][63:0];
    assign s1_last_dout = mem1[rd1[7:0]][64];
    always @(posedge clk) begin
        if (s0_read) rd0 <= rd0 + 1;
        if (s1_read) rd1 <= rd1 + 1;
    end
    // Core model: sums the NC accepted words, answers lat cycles after the last one.
    logic [2:0] cb;
    logic [W-1:0] acc, res;
    int cdly, lat = 5;
    logic core_en = 1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cb <= 0; acc <= 0; res <= 0; cdly <= 0; qr_out_valid <= 0; qr_out <= 0;
        end else begin
            qr_out_valid <= 0;
            if (cdly != 0) cdly <= cdly - 1;
            if (cdly == 1) begin qr_out_valid <= core_en; qr_out <= res; end
            if (qr_valid) begin
                cb  <= cb + 1;
                acc <= (cb == 7) ? '0 : acc + qr_in;
                if (cb == 7) begin res <= acc + qr_in; cdly <= lat; end
            end
        end
    end
    int errors = 0, checks = 0;
    int rc0 = 0, rc1 = 0, qv = 0, wr = 0, ef = 0, et = 0, since_rd = 0;
    logic wr_prev = 0, gchk = 0;
    exp_t sb[$];
    exp_t e;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic load(input bit ch, input bit ramp, input int last_beat, input bit push);
        logic [63:0] w;
        logic [W-1:0] s = '0;
        for (int k = 0; k < NC; k++) begin
            w = ramp ? 64'(k + 1) : {$urandom, $urandom};
            s += w[W-1:0];
            if (ch) begin mem1[lim1[7:0]] = {1'(k == last_beat), w}; lim1++; end
            else begin mem0[lim0[7:0]] = {1'(k == last_beat), w}; lim0++; end
        end
        if (push) sb.push_back('{user: ch, data: 64'(s)});
    endtask
    task automatic wait_wr(input int n, input int budget);
        int c = 0;
        while (wr < n && c < budget) begin @(negedge clk); c++; end
        chk("write_arrived", 64'(wr >= n), 1);
        repeat (2) @(negedge clk);
    endtask
    always @(negedge clk) begin
        if (wr_prev) chk("busy_after_write", busy, 0);
        wr_prev = osif_write;
        if (s0_read || s1_read) begin
            chk("one_read", s0_read & s1_read, 0);
            if (gchk && sb.size() > 0) chk("read_channel", s1_read, sb[0].user);
            rc0 += int'(s0_read);
            rc1 += int'(s1_read);
            since_rd = 0;
        end else since_rd++;
        if (qr_valid) qv++;
        if (err_frame) ef++;
        if (err_timeout) begin et++; chk("timeout_latency", 64'(since_rd), TO + 1); end
        if (osif_write) begin
            wr++;
            chk("write_expected", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_data", osif_data_din, e.data);
                chk("wr_user", osif_user_din, e.user);
                chk("wr_last", osif_last_din, 1);
                chk("wr_strb", osif_strb_din, 8'hff);
            end
        end
    end
    int b0, b1, bq, bw, be, c, start;
    initial begin
        osif_full_n = 1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_write", osif_write, 0);
        chk("rst_strb", osif_strb_din, 8'hff);
        chk("rst_data", osif_data_din, 0);
        chk("rst_read", s0_read | s1_read, 0);
        chk("rst_qr_valid", qr_valid, 0);
        chk("rst_errs", {err_frame, err_timeout}, 0);
        rst = 0;
        @(negedge clk);
        // Round-robin: three matrices per channel, grants must alternate from 0.
        b0 = rc0; b1 = rc1; bw = wr;
        for (int m = 0; m < 3; m++) begin load(0, 0, 7, 1); load(1, 0, 7, 1); end
        gchk = 1; en0 = 1; en1 = 1;
        wait_wr(bw + 6, 3000);
        gchk = 0;
        chk("rr_reads0", 64'(rc0 - b0), 24);
        chk("rr_reads1", 64'(rc1 - b1), 24);
        // Single channel-0 ramp matrix.
        b0 = rc0; bq = qv; bw = wr;
        load(0, 1, 7, 1);
        wait_wr(bw + 1, 200);
        chk("single_reads", 64'(rc0 - b0), 8);
        chk("single_qr_valid", 64'(qv - bq), 8);
        chk("single_writes", 64'(wr - bw), 1);
        chk("single_idle", busy, 0);
        // Gapped channel 1 with output backpressure.
        osif_full_n = 0; en1 = 0; b1 = rc1; bq = qv; bw = wr;
        load(1, 0, 7, 1);
        for (int i = 0; i < 40; i++) begin @(negedge clk); en1 = ~en1; end
        en1 = 1;
        chk("gap_reads", 64'(rc1 - b1), 8);
        chk("gap_qr_valid", 64'(qv - bq), 8);
        chk("held_writes", 64'(wr - bw), 0);
        chk("held_busy", busy, 1);
        osif_full_n = 1;
        wait_wr(bw + 1, 50);
        // Frame errors: early last, then missing last.
        be = ef; b0 = rc0; bw = wr;
        load(0, 0, 4, 1);
        wait_wr(bw + 1, 200);
        chk("early_last_pulses", 64'(ef - be), 1);
        chk("early_last_reads", 64'(rc0 - b0), 8);
        be = ef;
        load(0, 0, -1, 1);
        wait_wr(bw + 2, 200);
        chk("missing_last_pulses", 64'(ef - be), 1);
        // Timeout on channel 1, then the next grant must go to channel 0.
        core_en = 0; be = et; bw = wr;
        load(1, 0, 7, 0);
        c = 0;
        while (et == be && c < 400) begin @(negedge clk); c++; end
        chk("timeout_pulses", 64'(et - be), 1);
        chk("timeout_no_write", 64'(wr - bw), 0);
        core_en = 1;
        @(negedge clk);
        load(0, 0, 7, 1); load(1, 0, 7, 1);
        gchk = 1;
        wait_wr(bw + 2, 400);
        // Leave the pointer on channel 1 before the reset test.
        load(0, 0, 7, 1);
        wait_wr(bw + 3, 200);
        // Reset on beat 4 of channel 1.
        load(1, 0, 7, 0);
        start = rd1; c = 0;
        while (!(s1_read && rd1 == start + 3) && c < 100) begin @(negedge clk); c++; end
        chk("reset_point_reached", 64'(c < 100), 1);
        rst = 1;
        #1;
        chk("mid_rst_read", s1_read, 0);
        chk("mid_rst_qr_valid", qr_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_write", osif_write, 0);
        lim1 = rd1;
        @(negedge clk);
        rst = 0;
        bw = wr;
        load(0, 0, 7, 1); load(1, 0, 7, 1);
        wait_wr(bw + 2, 400);
        gchk = 0;
        chk("scoreboard_empty", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
